// File: rtl/cache_mem_pkg.sv
// Shared encodings, constants and address helper for the cache/memory arbiter.
// The main memory is shared by the I-cache and the D-cache.
package cache_mem_pkg;

  localparam int MEM_LATENCY     = 4;
  localparam int WORDS_PER_BLOCK = 8;

  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
  localparam logic [15:0] WORD_STRIDE = 16'd2;
  localparam logic [2:0]  LAST_WORD   = 3'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } state_t;

  // The base is block aligned, so the word offset never carries past bit 3.
  function automatic logic [15:0] word_addr(input logic [15:0] base,
                                            input logic [2:0]  idx);
    return base + (16'(idx) * WORD_STRIDE);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_counter.sv
// Issue and return word counters for one 8-word block fill.
// These counters are shared by whichever cache currently holds the grant.
module mem_fill_counter
  import cache_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       issue_inc,
  input  logic       ret_inc,
  output logic [2:0] issue_cnt,
  output logic [2:0] ret_cnt,
  output logic       issue_done,
  output logic       last_return
);

  // The issue counter wraps after the last word, so a sticky flag marks completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt  <= 3'd0;
      ret_cnt    <= 3'd0;
      issue_done <= 1'b0;
    end else if (clear) begin
      issue_cnt  <= 3'd0;
      ret_cnt    <= 3'd0;
      issue_done <= 1'b0;
    end else begin
      if (issue_inc) begin
        issue_cnt <= issue_cnt + 3'd1;
        if (issue_cnt == LAST_WORD) begin
          issue_done <= 1'b1;
        end
      end
      if (ret_inc) begin
        ret_cnt <= ret_cnt + 3'd1;
      end
    end
  end

  assign last_return = (ret_cnt == LAST_WORD);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Grants the shared main memory to the I-cache or the D-cache and sequences block fills.
// It also forwards D-cache write-through stores to memory.
module cache_mem_arbiter
  import cache_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        d_wr_ack,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic [15:0] fill_data,
  output logic        i_busy,
  output logic        d_busy,
  output logic        i_write_data_array,
  output logic        d_write_data_array,
  output logic        i_write_tag_array,
  output logic        d_write_tag_array,
  output logic [15:0] i_fill_addr,
  output logic [15:0] d_fill_addr
);

  state_t      state_r, state_nx_s;
  logic [15:0] base_r, base_nx_s;
  logic [15:0] ret_addr_s;
  logic        clear_s, issue_inc_s, ret_inc_s;
  logic        issue_done_s, last_return_s;
  logic [2:0]  issue_cnt_s, ret_cnt_s;

  mem_fill_counter u_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear_s),
    .issue_inc   (issue_inc_s),
    .ret_inc     (ret_inc_s),
    .issue_cnt   (issue_cnt_s),
    .ret_cnt     (ret_cnt_s),
    .issue_done  (issue_done_s),
    .last_return (last_return_s)
  );

  // State and latched block base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      base_r  <= 16'h0000;
    end else begin
      state_r <= state_nx_s;
      base_r  <= base_nx_s;
    end
  end

  // Grant, issue and return steering; returns outside a fill state are dropped.
  always_comb begin
    state_nx_s         = state_r;
    base_nx_s          = base_r;
    clear_s            = 1'b0;
    issue_inc_s        = 1'b0;
    ret_inc_s          = 1'b0;
    mem_enable         = 1'b0;
    mem_wr             = 1'b0;
    mem_addr           = 16'h0000;
    mem_data_in        = 16'h0000;
    d_wr_ack           = 1'b0;
    i_write_data_array = 1'b0;
    d_write_data_array = 1'b0;
    i_write_tag_array  = 1'b0;
    d_write_tag_array  = 1'b0;
    i_fill_addr        = 16'h0000;
    d_fill_addr        = 16'h0000;
    ret_addr_s         = word_addr(base_r, ret_cnt_s);

    case (state_r)
      IDLE: begin
        if (d_wr_req) begin
          state_nx_s = D_WRITE;
        end else if (d_miss) begin
          state_nx_s = D_FILL;
          base_nx_s  = d_miss_addr & BLOCK_MASK;
          clear_s    = 1'b1;
        end else if (i_miss) begin
          state_nx_s = I_FILL;
          base_nx_s  = i_miss_addr & BLOCK_MASK;
          clear_s    = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end

      I_FILL, D_FILL: begin
        if (!issue_done_s) begin
          mem_enable  = 1'b1;
          mem_addr    = word_addr(base_r, issue_cnt_s);
          issue_inc_s = 1'b1;
        end else begin
          issue_inc_s = 1'b0;
        end
        if (mem_data_valid) begin
          ret_inc_s = 1'b1;
          if (state_r == I_FILL) begin
            i_write_data_array = 1'b1;
            i_fill_addr        = ret_addr_s;
            i_write_tag_array  = last_return_s;
          end else begin
            d_write_data_array = 1'b1;
            d_fill_addr        = ret_addr_s;
            d_write_tag_array  = last_return_s;
          end
          if (last_return_s) begin
            state_nx_s = IDLE;
          end else begin
            state_nx_s = state_r;
          end
        end else begin
          ret_inc_s = 1'b0;
        end
      end

      D_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = d_wr_addr;
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
        state_nx_s  = IDLE;
      end

      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  assign i_busy    = (state_r == I_FILL);
  assign d_busy    = (state_r == D_FILL);
  assign fill_data = mem_data_out;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a pipelined memory model and fill scoreboard.
// The memory returns the bitwise complement of each word address.
module tb_cache_mem_arbiter;

  localparam int LAT = cache_mem_pkg::MEM_LATENCY;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0, d_miss = 1'b0, d_wr_req = 1'b0;
  logic [15:0] i_miss_addr = 16'h0000, d_miss_addr = 16'h0000;
  logic [15:0] d_wr_addr = 16'h0000, d_wr_data = 16'h0000;
  logic        d_wr_ack, mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_data_in, mem_data_out, fill_data;
  logic        mem_data_valid;
  logic        i_busy, d_busy, i_write_data_array, d_write_data_array;
  logic        i_write_tag_array, d_write_tag_array;
  logic [15:0] i_fill_addr, d_fill_addr;

  logic        spur_valid = 1'b0;
  logic [15:0] spur_data = 16'h0000;
  logic        v_p [LAT];
  logic [15:0] a_p [LAT];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_d;
    logic [15:0] addr;
    bit          last;
  } exp_t;
  exp_t sb[$];

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_ack(d_wr_ack),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid), .fill_data(fill_data),
    .i_busy(i_busy), .d_busy(d_busy),
    .i_write_data_array(i_write_data_array), .d_write_data_array(d_write_data_array),
    .i_write_tag_array(i_write_tag_array), .d_write_tag_array(d_write_tag_array),
    .i_fill_addr(i_fill_addr), .d_fill_addr(d_fill_addr)
  );

  always #5 clk = ~clk;

  // Pipelined memory: a read request appears as valid data LAT cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        v_p[i] <= 1'b0;
        a_p[i] <= 16'h0000;
      end
    end else begin
      v_p[0] <= mem_enable && !mem_wr;
      a_p[0] <= mem_addr;
      for (int i = 1; i < LAT; i++) begin
        v_p[i] <= v_p[i-1];
        a_p[i] <= a_p[i-1];
      end
    end
  end

  assign mem_data_valid = v_p[LAT-1] | spur_valid;
  assign mem_data_out   = spur_valid ? spur_data : ~a_p[LAT-1];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every array write must match the next expected fill word.
  always @(negedge clk) begin
    exp_t e;
    if (i_write_data_array || d_write_data_array) begin
      check("sb_nonempty", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_cache", 16'(d_write_data_array), 16'(e.is_d));
        check("sb_other_cache", 16'(i_write_data_array & d_write_data_array), 16'd0);
        check("sb_fill_addr", e.is_d ? d_fill_addr : i_fill_addr, e.addr);
        check("sb_fill_data", fill_data, ~e.addr);
        check("sb_tag", 16'(e.is_d ? d_write_tag_array : i_write_tag_array), 16'(e.last));
      end
    end
    if (i_write_tag_array) check("i_tag_needs_data", 16'(i_write_data_array), 16'd1);
    if (d_write_tag_array) check("d_tag_needs_data", 16'(d_write_data_array), 16'd1);
  end

  // Called in the grant cycle with the miss already driven; returns in cycle 13 (IDLE).
  task automatic fill_window(input bit is_d, input logic [15:0] miss_addr);
    logic [15:0] base;
    base = miss_addr & 16'hFFF0;
    for (int n = 0; n < 8; n++) sb.push_back('{is_d, base + 16'(2 * n), (n == 7)});
    for (int c = 1; c <= 13; c++) begin
      cyc();
      if (c == 3) begin
        if (is_d) d_miss_addr = 16'hFFFE;
        else      i_miss_addr = 16'hFFFE;
      end
      if (c == 13) begin
        if (is_d) d_miss = 1'b0;
        else      i_miss = 1'b0;
      end
      #1;
      check("fill_mem_enable", 16'(mem_enable), 16'(c <= 8));
      check("fill_mem_wr", 16'(mem_wr), 16'd0);
      check("fill_mem_addr", mem_addr, (c <= 8) ? base + 16'(2 * (c - 1)) : 16'h0000);
      check("fill_busy", 16'(is_d ? d_busy : i_busy), 16'(c <= 12));
      check("fill_other_busy", 16'(is_d ? i_busy : d_busy), 16'd0);
      check("fill_data_we", 16'(is_d ? d_write_data_array : i_write_data_array),
            16'(c >= 5 && c <= 12));
      check("fill_tag_we", 16'(is_d ? d_write_tag_array : i_write_tag_array), 16'(c == 12));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state.
    #3;
    check("rst_mem_enable", 16'(mem_enable), 16'd0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_busy", 16'({i_busy, d_busy}), 16'd0);
    check("rst_we", 16'({i_write_data_array, d_write_data_array,
                         i_write_tag_array, d_write_tag_array}), 16'd0);
    check("rst_fill_addr", i_fill_addr | d_fill_addr, 16'h0000);
    check("rst_ack", 16'(d_wr_ack), 16'd0);
    check("rst_fill_data", fill_data, 16'hFFFF);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Single I-cache fill, miss address changed mid-fill.
    cyc();
    i_miss = 1'b1; i_miss_addr = 16'h1234;
    #1;
    check("grant_cycle_idle", 16'(mem_enable), 16'd0);
    fill_window(1'b0, 16'h1234);
    cyc(); cyc();

    // Simultaneous misses: D-cache first, I-cache granted in cycle 13.
    cyc();
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    d_miss = 1'b1; d_miss_addr = 16'h8010;
    fill_window(1'b1, 16'h8010);
    fill_window(1'b0, 16'h0040);
    cyc(); cyc();

    // Store together with an I-cache miss.
    cyc();
    d_wr_req = 1'b1; d_wr_addr = 16'h00A2; d_wr_data = 16'hBEEF;
    i_miss = 1'b1; i_miss_addr = 16'h0100;
    #1;
    check("st_c0_enable", 16'(mem_enable), 16'd0);
    cyc(); #1;
    check("st_mem_enable", 16'(mem_enable), 16'd1);
    check("st_mem_wr", 16'(mem_wr), 16'd1);
    check("st_mem_addr", mem_addr, 16'h00A2);
    check("st_mem_data", mem_data_in, 16'hBEEF);
    check("st_ack", 16'(d_wr_ack), 16'd1);
    cyc();
    d_wr_req = 1'b0;
    #1;
    check("st_c2_ack", 16'(d_wr_ack), 16'd0);
    check("st_c2_enable", 16'(mem_enable), 16'd0);
    fill_window(1'b0, 16'h0100);
    cyc(); cyc();

    // Reset in cycle 7 of a D-cache fill.
    cyc();
    d_miss = 1'b1; d_miss_addr = 16'h2468;
    for (int n = 0; n < 8; n++) sb.push_back('{1'b1, 16'h2460 + 16'(2 * n), (n == 7)});
    for (int c = 1; c <= 6; c++) cyc();
    cyc();
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_enable", 16'(mem_enable), 16'd0);
    check("mid_rst_addr", mem_addr, 16'h0000);
    check("mid_rst_d_busy", 16'(d_busy), 16'd0);
    check("mid_rst_we", 16'({d_write_data_array, d_write_tag_array}), 16'd0);
    check("mid_rst_fill_addr", d_fill_addr, 16'h0000);
    d_miss = 1'b0;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc(); #1;
      check("post_rst_idle", 16'({d_busy, i_busy, mem_enable}), 16'd0);
    end
    cyc();
    i_miss = 1'b1; i_miss_addr = 16'h3456;
    fill_window(1'b0, 16'h3456);

    // Spurious valid in IDLE, then a normal fill to show the counters are intact.
    cyc();
    spur_valid = 1'b1; spur_data = 16'h1357;
    #1;
    check("spur_we", 16'({i_write_data_array, d_write_data_array,
                          i_write_tag_array, d_write_tag_array}), 16'd0);
    check("spur_fill_addr", i_fill_addr | d_fill_addr, 16'h0000);
    check("spur_fill_data", fill_data, 16'h1357);
    cyc();
    spur_valid = 1'b0;
    d_miss = 1'b1; d_miss_addr = 16'h7FF8;
    fill_window(1'b1, 16'h7FF8);
    cyc(); cyc();

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single pipelined main memory (memory4c) between the I-cache and D-cache. Grants one requester at a time and sequences 8-word block fills: it issues the eight word reads and steers the returning words into the granted cache's data array, then its tag array. It also forwards single-word D-cache write-through stores. It replaces the per-cache fill FSMs and sits between both caches and memory.

## Interface
- MEM_LATENCY, 4, cycles from a request cycle (mem_enable high) to its mem_data_valid cycle
- WORDS_PER_BLOCK, 8, 16-bit words per 16-byte block
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_miss  in  1  I-cache read miss, held until serviced
- i_miss_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache read miss, held until serviced
- d_miss_addr  in  16  D-cache miss byte address
- d_wr_req  in  1  D-cache store, held with addr/data until d_wr_ack
- d_wr_addr  in  16  store address
- d_wr_data  in  16  store data
- d_wr_ack  out  1  store accepted
- mem_enable  out  1  memory request strobe
- mem_wr  out  1  1 = write request
- mem_addr  out  16  memory address
- mem_data_in  out  16  memory write data
- mem_data_out  in  16  memory read data
- mem_data_valid  in  1  read data valid
- fill_data  out  16  mem_data_out passthrough to both caches
- i_busy, d_busy  out  1 each  fill in progress for that cache
- i_write_data_array, d_write_data_array  out  1 each  write fill_data at *_fill_addr
- i_write_tag_array, d_write_tag_array  out  1 each  write tag/valid (last word)
- i_fill_addr, d_fill_addr  out  16 each  address of the returning word

## Operation
- States: IDLE, I_FILL, D_FILL, D_WRITE; registered, 2-bit.
- IDLE grant priority: d_wr_req > d_miss > i_miss. The grant is evaluated every IDLE cycle, and the next state is entered at the following edge.
- On a fill grant, latch base = miss_addr & 16'hFFF0. Clear issue_cnt and ret_cnt (3-bit each).
- Fill issue: while issue_cnt < WORDS_PER_BLOCK:
  - mem_enable=1, mem_wr=0, mem_addr = base + {issue_cnt,1'b0}
  - issue_cnt increments each cycle
  - one request per cycle, back-to-back
- Fill return: mem_data_valid in a FILL state asserts the granted cache's write_data_array. Its fill_addr = base + {ret_cnt,1'b0}, and ret_cnt increments.
- Last return (ret_cnt==7 and valid): also assert write_tag_array that cycle, then go to IDLE.
- busy = (state == that cache's FILL); registered, so it is glitch-free.
- D_WRITE lasts one cycle: mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_ack=1, then IDLE. Writes produce no data_valid.
- Address arithmetic is 16-bit, and offsets never carry past bit 3.

## Timing
- Reset: state IDLE, counters 0, every output 0 (including mem_addr and *_fill_addr). fill_data follows mem_data_out.
- Fill, grant seen in cycle 0:
  - issues in cycles 1–8
  - returns in cycles 5–12
  - write_tag_array in cycle 12
  - IDLE and busy=0 in cycle 13
  - total 13 cycles at MEM_LATENCY=4
- Store: req seen in cycle 0, ack and memory write in cycle 1, IDLE in cycle 2.
- Simultaneous i_miss and d_miss: D-cache fill first. I-cache is granted in the IDLE cycle after the D-cache fill completes.
- Requester inputs or addresses changing mid-fill are ignored. The latched base is used.
- mem_data_valid in IDLE or D_WRITE is ignored (no array writes).
- Reset mid-fill: immediate abort to reset values. memory4c shares rst, so no stale returns follow.
- A miss still asserted in the cycle after write_tag_array is the cache's responsibility. By then it re-evaluates as a hit.

## Structure
- Package cache_mem_pkg holds:
  - state encodings IDLE=0, I_FILL=1, D_FILL=2, D_WRITE=3
  - BLOCK_MASK=16'hFFF0
  - WORD_STRIDE=2
- Sub-module mem_fill_counter holds issue_cnt/ret_cnt with clear, increment, issue_done and last_return flags. It is instantiated once.

## Test plan
- i_miss at 0x1234 only, memory word n = 0x1230+2n:
  - mem_addr reads 0x1230..0x123E in cycles 1–8
  - i_write_data_array in cycles 5–12 with i_fill_addr 0x1230..0x123E
  - i_write_tag_array only in cycle 12; i_busy falls in cycle 13
- i_miss at 0x0040 and d_miss at 0x8010 in the same cycle:
  - full D-cache fill of 0x8010–0x801E first, with i_busy=0 throughout
  - I-cache fill of 0x0040–0x004E starts at cycle 14
- d_wr_req at 0x00A2 / 0xBEEF together with i_miss:
  - cycle 1: mem_wr=1, addr 0x00A2, data 0xBEEF, d_wr_ack=1
  - I-cache fill is granted in cycle 2 and its issues start in cycle 3
- rst pulsed in cycle 7 of a D-cache fill:
  - all outputs 0 immediately
  - no d_write_tag_array
  - subsequent i_miss fills normally
- Spurious mem_data_valid in IDLE: no write_data_array or tag write asserted, counters unchanged.
